// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite SRAM responder: byte/halfword/word singles with byte-lane writes, 2-cycle ERROR for illegal accesses.
// Latency: zero-wait OKAY data phase; with AHB_SRAM_WAIT_STATES_EN defined, WAIT_STATES extra stall cycles per OKAY transfer.
// Backpressure: HREADYOUT low during ERR1 (and WAIT when AHB_SRAM_WAIT_STATES_EN is defined); address phase accepted only when HREADY is high.
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [HDATA_SIZE-1:0] HRDATA
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [HADDR_SIZE-1:0] BYTE_LIMIT = HADDR_SIZE'(4 * MEM_DEPTH);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DATA = 3'd1;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;
`ifdef AHB_SRAM_WAIT_STATES_EN
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam int         CW      = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    // A legal transfer stalls first unless no wait states were asked for
    localparam logic [2:0] ST_OK_ENTRY = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
`else
    localparam logic [2:0] ST_OK_ENTRY = ST_DATA;
`endif

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    logic [2:0]    state, state_nxt;
    logic [AW+1:0] addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic          err_q;

    logic          accept;
    logic          acc_err;
    logic [AW-1:0] word_idx;
    logic [3:0]    lane_en;
    logic          wr_commit;
    logic          rd_active;
    logic          stall;

    assign accept   = HSEL & HTRANS[1] & HREADY;
    assign word_idx = addr_q[AW+1:2];

    // Illegal: unknown size, misaligned halfword/word, or beyond the memory
    assign acc_err = (HSIZE > 3'd2)
                   | ((HSIZE == 3'd1) & HADDR[0])
                   | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                   | (HADDR >= BYTE_LIMIT);

`ifdef AHB_SRAM_WAIT_STATES_EN
    logic [CW-1:0] wait_cnt;

    // Down-counter loaded on a legal accept, counts the WAIT cycles
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wait_cnt <= '0;
        end else if (accept && !acc_err && (state != ST_ERR1) && (state != ST_WAIT)) begin
            wait_cnt <= CW'(WAIT_STATES - 1);
        end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign stall = (state == ST_ERR1) | (state == ST_WAIT);
`else
    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, 32'(WAIT_STATES)};
    assign stall     = (state == ST_ERR1);
`endif

    // Next state: ERR1 always runs into ERR2; completing states may take a pipelined accept
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_ERR1: state_nxt = ST_ERR2;
`ifdef AHB_SRAM_WAIT_STATES_EN
            ST_WAIT: state_nxt = (wait_cnt == '0) ? ST_DATA : ST_WAIT;
`endif
            default: begin
                if (accept) begin
                    state_nxt = acc_err ? ST_ERR1 : ST_OK_ENTRY;
                end
            end
        endcase
    end

    // State and address-phase capture; reset abandons any transfer in flight
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= HADDR[AW+1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
                err_q   <= acc_err;
            end
        end
    end

    // Byte lanes touched by the registered size/offset
    always_comb begin
        lane_en = 4'b1111;
        case (size_q)
            3'd0:    lane_en = 4'b0001 << addr_q[1:0];
            3'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    assign wr_commit = HRESETn & (state == ST_DATA) & write_q & ~err_q;
    assign rd_active = HRESETn & (state == ST_DATA) & ~write_q & ~err_q;

    // Lane-masked write on the completing data-phase cycle; memory is never reset
    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HREADYOUT = ~HRESETn | ~stall;
    assign HRESP     = HRESETn & ((state == ST_ERR1) | (state == ST_ERR2));
    assign HRDATA    = rd_active ? mem[word_idx] : '0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Randomised AHB-Lite traffic against ahb3lite_sram_slave with a byte-addressed reference memory.
// Expected responses are queued at issue; a bus monitor pops and compares at each data-phase completion.
// Stalls are counted per transfer so ERROR and wait timing are checked as well as data.
module tb_ahb3lite_sram_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    always #5 HCLK = ~HCLK;

    assign HREADY = HREADYOUT;

    ahb3lite_sram_slave #(
        .HADDR_SIZE (32),
        .HDATA_SIZE (32),
        .MEM_DEPTH  (1024),
        .WAIT_STATES(2)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HPROT    (HPROT),
        .HTRANS   (HTRANS),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .HRDATA   (HRDATA)
    );

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          stalls;
    } exp_t;

    exp_t    expq[$];
    byte unsigned bm [int];
    int      checks   = 0;
    int      failures = 0;

`ifdef AHB_SRAM_WAIT_STATES_EN
    localparam int OK_WAITS = 2;
`else
    localparam int OK_WAITS = 0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit   dphase = 1'b0;
    int   stalls = 0;
    exp_t cur;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            check("reset_hreadyout", 32'(HREADYOUT), 32'd1);
            check("reset_hresp", 32'(HRESP), 32'd0);
            check("reset_hrdata", HRDATA, 32'd0);
            dphase = 1'b0;
            stalls = 0;
        end else begin
            if (dphase) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_data_phase actual=busy required=no_transfer at %0t", $time);
                    dphase = 1'b0;
                end else if (!HREADYOUT) begin
                    stalls++;
                    check("stall_hresp", 32'(HRESP), 32'(expq[0].err));
                end else begin
                    cur = expq.pop_front();
                    check("resp", 32'(HRESP), 32'(cur.err));
                    check("stall_count", 32'(stalls), 32'(cur.stalls));
                    check("hrdata", HRDATA, (cur.rd && !cur.err) ? cur.data : 32'd0);
                    dphase = 1'b0;
                    stalls = 0;
                end
            end else begin
                check("idle_hreadyout", 32'(HREADYOUT), 32'd1);
                check("idle_hresp", 32'(HRESP), 32'd0);
                check("idle_hrdata", HRDATA, 32'd0);
            end
            if (HREADYOUT && HSEL && HTRANS[1]) dphase = 1'b1;
        end
    end

    // ---------------- reference model ----------------
    function automatic bit model_err(input logic [2:0] sz, input logic [31:0] a);
        if (sz > 3'd2) return 1'b1;
        if ((a % (32'd1 << sz)) != 0) return 1'b1;
        return a >= 32'd4096;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        logic [31:0] w;
        base = int'(a) & ~3;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = bm[base + i];
        return w;
    endfunction

    task automatic model_write(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        int nb;
        int ba;
        nb = 1 << sz;
        for (int i = 0; i < nb; i++) begin
            ba = int'(a) + i;
            bm[ba] = d[8*(ba % 4) +: 8];
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic park();
        HSEL   = 1'($urandom);
        HTRANS = HSEL ? 2'($urandom_range(0, 1)) : 2'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            park();
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic xfer(input bit w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input bit push);
        exp_t e;
        bit   r;
        int   n;
        HSEL   = 1'b1;
        HTRANS = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        HADDR  = a;
        HWRITE = w;
        HSIZE  = sz;
        HBURST = 3'($urandom);
        HPROT  = 4'($urandom);
        n = 0;
        forever begin
            r = HREADY;
            @(posedge HCLK);
            #1;
            if (r) break;
            n++;
            if (n > 20) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=HREADY_low required=accept_within_20 at %0t", $time);
                break;
            end
        end
        HWDATA = d;
        park();
        if (push) begin
            e.err    = model_err(sz, a);
            e.rd     = !w;
            e.stalls = e.err ? 1 : OK_WAITS;
            if (!e.err && w) model_write(sz, a, d);
            e.data   = (!e.err && !w) ? model_word(a) : 32'd0;
            expq.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          wsel;
        logic [31:0] a;
        logic [2:0]  sz;
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = '0;
        HWRITE  = 1'b0;
        HSIZE   = 3'd0;
        HBURST  = 3'd0;
        HPROT   = 4'd0;
        HTRANS  = 2'b00;
        HWDATA  = '0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle(2);

        // Fill the working set: low words 0..15 and the top four words
        for (int w = 0; w < 20; w++) begin
            a = (w < 16) ? 32'(4 * w) : 32'(4 * (1004 + w));
            xfer(1'b1, 3'd2, a, $urandom, 1'b1);
        end
        idle(2);

        // Halfword/byte merge sequence and the two error shapes
        xfer(1'b1, 3'd1, 32'h0, 32'h0000BEEF, 1'b1);
        xfer(1'b0, 3'd1, 32'h0, $urandom, 1'b1);
        xfer(1'b1, 3'd1, 32'h2, 32'hDEAD0000, 1'b1);
        xfer(1'b0, 3'd2, 32'h0, $urandom, 1'b1);
        xfer(1'b1, 3'd0, 32'h1, 32'h000000AA, 1'b1);
        xfer(1'b0, 3'd2, 32'h0, $urandom, 1'b1);
        xfer(1'b1, 3'd1, 32'h1, 32'h55555555, 1'b1);
        xfer(1'b0, 3'd2, 32'h0, $urandom, 1'b1);
        xfer(1'b0, 3'd2, 32'h1000, $urandom, 1'b1);
        xfer(1'b0, 3'd2, 32'h0, $urandom, 1'b1);
        idle(1);

        // Reset during a write data phase: write abandoned, word unchanged
        xfer(1'b1, 3'd2, 32'h10, 32'hA5A5A5A5, 1'b0);
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HTRANS  = 2'b00;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle(1);
        xfer(1'b0, 3'd2, 32'h10, $urandom, 1'b1);
        idle(1);

        // Random traffic, pipelined with occasional idle/busy/deselected gaps
        for (int i = 0; i < 300; i++) begin
            wsel = $urandom_range(0, 19);
            a    = (wsel < 16) ? 32'(4 * wsel) : 32'(4 * (1004 + wsel));
            a    = a + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = 32'h1000 + 32'($urandom_range(0, 64));
            sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            xfer(1'($urandom), sz, a, $urandom, 1'b1);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
        end

        // Drain with a bounded wait
        for (int i = 0; i < 50 && (expq.size() != 0 || dphase); i++) idle(1);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d_pending required=0_pending", expq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
